echo_capture: RTL and testbench
===============================

Name: echo_capture

Overview:
- Receive side of the ultrasonic ranging interface.
- After the `trig` block fires a trigger pulse, this block is armed. It then times the sensor's echo-high pulse in clock cycles and reports the width, or an error, to the ranging controller.
- Sits between the `echo` input pad and the controller, alongside `trig`.

Parameters:
- CNT_W, 16, width of the echo pulse-width counter and the `width` output.
- ARM_TO, 1000, maximum cycles to wait in ARMED for an echo rising edge before reporting "no echo".
- SYNC_STAGES, 2, number of flops in the `echo` input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  arm request; sampled only while `ready`=1.
- echo  input  1  raw asynchronous echo line from the sensor.
- ready  output  1  1 when idle and able to accept `start`.
- valid  output  1  one-cycle pulse when a result (`width` and `err`) is updated.
- width  output  CNT_W  measured echo-high width in clk cycles; held until the next `valid`.
- err  output  2  00 ok, 01 no echo (arm timeout), 10 overflow (echo still high at counter max); held with `width`.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=1, valid=0, width=0, err=00.
  - synchronizer flops and edge register cleared to 0.
  - internal counters cleared.
- Input conditioning:
  - `echo` passes through SYNC_STAGES flops to give `echo_s`.
  - A 1-cycle-delayed copy `echo_d` gives `rise` = echo_s & ~echo_d and `fall` = ~echo_s & echo_d.
  - Both edges see the same latency, so the measured width is exact: an N-cycle pin pulse measures as N.
- IDLE:
  - ready=1.
  - start=1 -> ARMED, with arm counter cleared. Next cycle ready=0.
- ARMED:
  - Arm counter increments every cycle.
  - `rise` -> MEASURE, width counter loaded with 1.
  - Arm counter reaches ARM_TO-1 with no `rise` -> DONE with width=0, err=01.
  - If `echo` is already high when armed, that pulse is ignored; only a fresh rising edge is accepted.
  - If `rise` and the timeout occur in the same cycle, `rise` wins.
- MEASURE:
  - While echo_s=1, the width counter increments each cycle.
  - `fall` -> DONE with width = counter value, err=00.
  - Counter reaches 2^CNT_W-1 while echo_s is still 1 -> DONE with width=2^CNT_W-1 (saturated), err=10. No wrap-around.
  - If `fall` and saturation occur in the same cycle, `fall` wins and err=00.
- DONE:
  - Lasts 1 cycle. `width` and `err` registers are updated, valid=1.
  - Next cycle -> IDLE, valid=0, ready=1.
- Latency:
  - echo fall at the pin -> valid = SYNC_STAGES+2 cycles.
  - Arm timeout -> valid exactly ARM_TO+1 cycles after the start-accept edge.
- start while ready=0 is ignored; there is no queueing.
- Outputs are registered, with no combinational path from inputs to outputs.
- A reset asserted mid-operation aborts immediately: no valid is produced and all outputs return to their reset values.
- After a result, the next start re-arms cleanly. Any echo activity seen between measurements is discarded.

Decomposition:
- Shared package (`udar_pkg`):
  - state encoding constants IDLE, ARMED, MEASURE, DONE.
  - err codes ERR_OK=2'b00, ERR_NOECHO=2'b01, ERR_OVF=2'b10.
- One sub-module, `sync_edge`:
  - parameterised multi-flop synchronizer plus `rise`/`fall` detector, with async active-low reset.
  - reusable by other sensor inputs.
- The FSM and counters stay in `echo_capture`.

Test Plan:
- Reset sanity: rst=0 for 100 ns, then 1 -> ready=1, valid=0, width=0, err=00. Toggling echo with no start gives no valid.
- Nominal: start for 1 cycle; 200 ns later drive echo high for 580 ns (clk 10 ns) -> single valid pulse, width=58, err=00, ready returns 1 the cycle after valid.
- No echo: ARM_TO=1000, start, echo held 0 -> valid exactly 1001 cycles after start is accepted, width=0, err=01.
- Overflow: CNT_W=8, start, echo high for 400 cycles -> valid while echo is still high, width=255, err=10. The later echo fall produces no second valid.
- Pre-high echo: echo=1 before start, start, echo falls after 50 cycles, then rises for 30 cycles -> width=30, err=00.
- Reset mid-measure: start, echo high 100 cycles, rst=0 for 10 cycles, then start again with a 20-cycle echo -> no valid from the aborted run, second result width=20, err=00.

Source files
------------

// File: rtl/udar_pkg.sv
// Shared types for the ultrasonic ranging blocks: FSM state encoding and
// result error codes reported to the ranging controller.
package udar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_NOECHO = 2'b01,
    ERR_OVF    = 2'b10
  } err_e;

endpackage

// File: rtl/echo_capture_if.sv
// Controller-facing handshake of echo_capture: arm request in, result out.
interface echo_capture_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             ready;
  logic             valid;
  logic [CNT_W-1:0] width;
  logic [1:0]       err;

  modport master (output start, input ready, valid, width, err);
  modport slave  (input start, output ready, valid, width, err);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus rise/fall detection
// on the synchronized level. STAGES must be at least 2.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      d_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      d_q    <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~d_q;
  assign fall_o = ~sync_q[STAGES-1] &  d_q;

endmodule

// File: rtl/echo_capture.sv
// Times the sensor echo-high pulse after an arm request and reports its width
// in clk cycles, or a no-echo / overflow error, as a one-cycle valid result.
module echo_capture
  import udar_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int ARM_TO      = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            echo,
  echo_capture_if.slave   bus
);

  localparam int               AW      = (ARM_TO > 1) ? $clog2(ARM_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic echo_s, rise, fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst),
    .d_i    (echo),
    .q_o    (echo_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [AW-1:0]    arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_e             code_q, code_d;

  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [1:0]       err_q, err_d;

  logic accept;
  assign accept = (state_q == IDLE) && ready_q && bus.start;

  // NOTE: counters and result registers are plain flops, so all of them are
  // reset; nothing here is a memory array that could be left uninitialised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      arm_cnt_q <= '0;
      cnt_q     <= '0;
      code_q    <= ERR_OK;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      width_q   <= '0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      width_q   <= width_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ARMED;
          arm_cnt_d = '0;
        end
      end
      ARMED: begin
        arm_cnt_d = arm_cnt_q + 1'b1;
        // A rise on the timeout cycle still counts as an echo.
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (arm_cnt_q == AW'(ARM_TO - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          code_d  = ERR_NOECHO;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_d = DONE;
          code_d  = ERR_OK;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          code_d  = ERR_OVF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The result is published one cycle after DONE; ready comes back one cycle
  // after that, so a new start never overlaps the valid pulse.
  always_comb begin
    valid_d = (state_q == DONE);
    width_d = (state_q == DONE) ? cnt_q : width_q;
    err_d   = (state_q == DONE) ? code_q : err_q;
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  assign bus.ready = ready_q;
  assign bus.valid = valid_q;
  assign bus.width = width_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_echo_capture.sv
// Self-checking bench for echo_capture: table of echo pulses plus hand-written
// timeout, latency and mid-measure reset sequences, with a result scoreboard.
module tb_echo_capture;
  import udar_pkg::*;

  localparam int CNT_W       = 8;
  localparam int ARM_TO      = 1000;
  localparam int SYNC_STAGES = 2;

  logic clk, rst, echo;

  echo_capture_if #(.CNT_W(CNT_W)) bus ();

  echo_capture #(
    .CNT_W       (CNT_W),
    .ARM_TO      (ARM_TO),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .echo (echo),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         pre_high;
    int         gap;
    int         len;
    int         exp_w;
    logic [1:0] exp_e;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] w;
    logic [1:0]       e;
  } exp_t;

  exp_t sb[$];
  exp_t got_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   n_pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int w, input logic [1:0] e);
    exp_t x;
    x.w = CNT_W'(w);
    x.e = e;
    sb.push_back(x);
    n_pushed++;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (bus.ready === 1'b1) break;
      step(1);
    end
    check("ready_before_start", 32'(bus.ready), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    check("result_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    if (v.pre_high) begin
      echo = 1'b1;
      step(5);
    end
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    push_exp(v.exp_w, v.exp_e);
    step(v.gap);
    if (v.pre_high) begin
      echo = 1'b0;
      step(10);
    end
    echo = 1'b1;
    step(v.len);
    echo = 1'b0;
    wait_done();
    step(10);
  endtask

  // Scoreboard monitor: every valid must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        got_exp = sb.pop_front();
        check("width", 32'(bus.width), 32'(got_exp.w));
        check("err", 32'(bus.err), 32'(got_exp.e));
        check("ready_low_during_valid", 32'(bus.ready), 0);
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.valid), 0);
        check("ready_after_valid", 32'(bus.ready), 1);
      end
    end
  end

  vec_t vecs[7];
  int   edges;

  initial begin
    vecs[0] = '{pre_high: 0, gap: 20, len: 58,  exp_w: 58,  exp_e: ERR_OK};
    vecs[1] = '{pre_high: 1, gap: 50, len: 30,  exp_w: 30,  exp_e: ERR_OK};
    vecs[2] = '{pre_high: 0, gap: 5,  len: 1,   exp_w: 1,   exp_e: ERR_OK};
    vecs[3] = '{pre_high: 0, gap: 3,  len: 2,   exp_w: 2,   exp_e: ERR_OK};
    vecs[4] = '{pre_high: 0, gap: 3,  len: 255, exp_w: 255, exp_e: ERR_OK};
    vecs[5] = '{pre_high: 0, gap: 7,  len: 400, exp_w: 255, exp_e: ERR_OVF};
    vecs[6] = '{pre_high: 0, gap: 4,  len: 200, exp_w: 200, exp_e: ERR_OK};

    rst       = 1'b0;
    bus.start = 1'b0;
    echo      = 1'b0;
    #100;
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_width", 32'(bus.width), 0);
    check("rst_err",   32'(bus.err),   0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Echo activity with no arm request must produce nothing.
    for (int i = 0; i < 5; i++) begin
      echo = 1'b1;
      step(3);
      echo = 1'b0;
      step(3);
    end
    step(20);
    check("idle_ready", 32'(bus.ready), 1);
    check("idle_no_valid", n_valid, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Arm timeout: valid exactly ARM_TO+1 cycles after the accept edge.
    wait_ready();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    push_exp(0, ERR_NOECHO);
    edges = 0;
    for (int i = 0; i < ARM_TO + 100; i++) begin
      @(posedge clk);
      #1 edges++;
      if (bus.valid === 1'b1) break;
    end
    check("noecho_latency", edges, ARM_TO + 1);
    wait_done();
    step(5);

    // Fall-to-valid latency, with a start pulse ignored mid-measure.
    wait_ready();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    push_exp(20, ERR_OK);
    step(5);
    echo = 1'b1;
    step(10);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(9);
    echo  = 1'b0;
    edges = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1 edges++;
      if (bus.valid === 1'b1) break;
    end
    check("fall_latency", edges, SYNC_STAGES + 2);
    wait_done();
    step(10);

    // Reset mid-measure: the aborted run must never report.
    wait_ready();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(5);
    echo = 1'b1;
    step(100);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 1);
    check("midrst_valid", 32'(bus.valid), 0);
    check("midrst_width", 32'(bus.width), 0);
    check("midrst_err",   32'(bus.err),   0);
    step(10);
    echo = 1'b0;
    rst  = 1'b1;
    step(5);
    run_vec('{pre_high: 0, gap: 5, len: 20, exp_w: 20, exp_e: ERR_OK});

    step(20);
    check("valid_count", n_valid, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
